alu_op_sequencer: RTL and testbench



---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_req_fifo.sv | 62 ++++++
 rtl/alu_op_sequencer.sv | 119 +++++++++++
 tb/tb_alu_op_sequencer.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: command codes, the parked command,
// the FSM state encoding and the request record stored in the request FIFO.
package alu_pkg;

    localparam logic [3:0] CMD_ADD  = 4'h0;
    localparam logic [3:0] CMD_SUB  = 4'h1;
    localparam logic [3:0] CMD_AND  = 4'h2;
    localparam logic [3:0] CMD_OR   = 4'h3;
    localparam logic [3:0] CMD_NOT  = 4'h4;
    localparam logic [3:0] CMD_PARK = 4'hF;
    localparam logic [3:0] CMD_MAX  = 4'h4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_CAPTURE,
        ST_RESP
    } seq_state_t;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] cmd;
    } alu_req_t;

    function automatic logic cmd_is_illegal(input logic [3:0] cmd);
        return cmd > CMD_MAX;
    endfunction

endpackage

// File: rtl/alu_req_fifo.sv
// DEPTH-entry synchronous FIFO of ALU requests (a, b, cmd). Show-ahead read port:
// rd_data always presents the head entry; push when full and pop when empty are ignored.
import alu_pkg::*;

module alu_req_fifo #(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             push,
    input  alu_req_t         wr_data,
    input  logic             pop,
    output alu_req_t         rd_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    alu_req_t         mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == DEPTH_CNT);
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage is not reset; a flush only needs the pointers and count cleared.
    always_ff @(posedge clk_in) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Issue stage for the combinational 8-bit ALU: queues requests, sequences each one
// through ISSUE/CAPTURE, and returns results in order. Optional ALU_SEQ_CMD_CHECK_EN.
import alu_pkg::*;

module alu_op_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        req_valid_in,
    output logic        req_ready_out,
    input  logic [7:0]  req_a_in,
    input  logic [7:0]  req_b_in,
    input  logic [3:0]  req_cmd_in,
    output logic [7:0]  alu_a_out,
    output logic [7:0]  alu_b_out,
    output logic [3:0]  alu_cmd_out,
    output logic        alu_oe_out,
    input  logic [15:0] alu_d_in,
    output logic        rsp_valid_out,
    input  logic        rsp_ready_in,
    output logic [15:0] rsp_data_out,
    output logic        rsp_err_out
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    seq_state_t       state;
    alu_req_t         wr_req;
    alu_req_t         head;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic             head_illegal;
    logic             op_illegal;

    assign wr_req        = '{a: req_a_in, b: req_b_in, cmd: req_cmd_in};
    assign req_ready_out = (fifo_count < DEPTH_CNT);
    assign fifo_push     = req_valid_in && !fifo_full;
    assign fifo_pop      = !fifo_empty &&
                           ((state == ST_IDLE) || ((state == ST_RESP) && rsp_ready_in));

`ifdef ALU_SEQ_CMD_CHECK_EN
    assign head_illegal = cmd_is_illegal(head.cmd);
`else
    assign head_illegal = 1'b0;
`endif

    alu_req_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .push    (fifo_push),
        .wr_data (wr_req),
        .pop     (fifo_pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Illegal commands keep the ALU parked and disabled but still walk the same
    // ISSUE/CAPTURE cycles, so response timing never depends on the command.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state         <= ST_IDLE;
            alu_a_out     <= '0;
            alu_b_out     <= '0;
            alu_cmd_out   <= CMD_PARK;
            alu_oe_out    <= 1'b0;
            rsp_valid_out <= 1'b0;
            rsp_data_out  <= '0;
            rsp_err_out   <= 1'b0;
            op_illegal    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        alu_a_out   <= head.a;
                        alu_b_out   <= head.b;
                        alu_cmd_out <= head_illegal ? CMD_PARK : head.cmd;
                        op_illegal  <= head_illegal;
                        state       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    alu_oe_out <= !op_illegal;
                    state      <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    alu_oe_out    <= 1'b0;
                    alu_cmd_out   <= CMD_PARK;
                    rsp_valid_out <= 1'b1;
                    rsp_data_out  <= op_illegal ? 16'h0000 : alu_d_in;
                    rsp_err_out   <= op_illegal;
                    state         <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready_in) begin
                        rsp_valid_out <= 1'b0;
                        if (!fifo_empty) begin
                            alu_a_out   <= head.a;
                            alu_b_out   <= head.b;
                            alu_cmd_out <= head_illegal ? CMD_PARK : head.cmd;
                            op_illegal  <= head_illegal;
                            state       <= ST_ISSUE;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: bench-side ALU, in-order response scoreboard
// and directed vectors with literal expectations. Honours ALU_SEQ_CMD_CHECK_EN.
module tb_alu_op_sequencer;

    logic        clk_in;
    logic        rst_in;
    logic        req_valid_in;
    logic        req_ready_out;
    logic [7:0]  req_a_in;
    logic [7:0]  req_b_in;
    logic [3:0]  req_cmd_in;
    logic [7:0]  alu_a_out;
    logic [7:0]  alu_b_out;
    logic [3:0]  alu_cmd_out;
    logic        alu_oe_out;
    logic [15:0] alu_d_in;
    logic        rsp_valid_out;
    logic        rsp_ready_in;
    logic [15:0] rsp_data_out;
    logic        rsp_err_out;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] cmd;
    } item_t;

    item_t       items [20];
    logic [16:0] exp_q [$];
    int          checks   = 0;
    int          failures = 0;
    logic        hold_prev = 1'b0;

    alu_op_sequencer #(.DEPTH(4)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .req_valid_in  (req_valid_in),
        .req_ready_out (req_ready_out),
        .req_a_in      (req_a_in),
        .req_b_in      (req_b_in),
        .req_cmd_in    (req_cmd_in),
        .alu_a_out     (alu_a_out),
        .alu_b_out     (alu_b_out),
        .alu_cmd_out   (alu_cmd_out),
        .alu_oe_out    (alu_oe_out),
        .alu_d_in      (alu_d_in),
        .rsp_valid_out (rsp_valid_out),
        .rsp_ready_in  (rsp_ready_in),
        .rsp_data_out  (rsp_data_out),
        .rsp_err_out   (rsp_err_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // The combinational ALU as the sequencer sees it; a poison value when disabled
    // exposes any capture taken without output-enable.
    function automatic logic [15:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                            input logic [3:0] cmd);
        case (cmd)
            4'h0:    return {8'h00, a} + {8'h00, b};
            4'h1:    return {8'h00, b} - {8'h00, a};
            4'h2:    return {8'h00, a & b};
            4'h3:    return {8'h00, a | b};
            4'h4:    return ~{8'h00, a};
            default: return 16'h0000;
        endcase
    endfunction

    assign alu_d_in = alu_oe_out ? alu_ref(alu_a_out, alu_b_out, alu_cmd_out) : 16'hDEAD;

    function automatic logic [16:0] model_rsp(input logic [7:0] a, input logic [7:0] b,
                                              input logic [3:0] cmd);
`ifdef ALU_SEQ_CMD_CHECK_EN
        if (cmd > 4'h4) return {1'b1, 16'h0000};
`endif
        return {1'b0, alu_ref(a, b, cmd)};
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Scoreboard bookkeeping on the active edge: accepted requests in, consumed responses out.
    always @(posedge clk_in) begin
        if (rst_in) begin
            exp_q.delete();
            hold_prev = 1'b0;
        end else begin
            if (rsp_valid_out && rsp_ready_in && exp_q.size() > 0) void'(exp_q.pop_front());
            if (req_valid_in && req_ready_out)
                exp_q.push_back(model_rsp(req_a_in, req_b_in, req_cmd_in));
            hold_prev = rsp_valid_out && !rsp_ready_in;
        end
    end

    // Every cycle a response is presented it must be the oldest outstanding one.
    always @(negedge clk_in) begin
        if (!rst_in) begin
            if (hold_prev) check_output("rsp_valid_hold", {31'b0, rsp_valid_out}, 32'd1);
            if (rsp_valid_out) begin
                if (exp_q.size() == 0) begin
                    check_output("rsp_unexpected", {31'b0, rsp_valid_out}, 32'd0);
                end else begin
                    check_output("sb_data", {16'b0, rsp_data_out}, {16'b0, exp_q[0][15:0]});
                    check_output("sb_err", {31'b0, rsp_err_out}, {31'b0, exp_q[0][16]});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic drive_item(input int idx);
        req_a_in   = items[idx].a;
        req_b_in   = items[idx].b;
        req_cmd_in = items[idx].cmd;
    endtask

    task automatic set_item(input int idx, input logic [7:0] a, input logic [7:0] b,
                            input logic [3:0] cmd);
        items[idx].a   = a;
        items[idx].b   = b;
        items[idx].cmd = cmd;
    endtask

    // One request, held until accepted; returns on the falling edge after acceptance.
    task automatic apply_stimulus(input logic [7:0] a, input logic [7:0] b,
                                  input logic [3:0] cmd);
        int guard = 0;
        req_valid_in = 1'b1;
        req_a_in     = a;
        req_b_in     = b;
        req_cmd_in   = cmd;
        while (!req_ready_out && guard < 40) begin
            @(negedge clk_in);
            guard++;
        end
        check_output("accept_timeout", {31'b0, req_ready_out}, 32'd1);
        @(negedge clk_in);
        req_valid_in = 1'b0;
    endtask

    task automatic stream_items(input int first, input int n);
        int   sent  = 0;
        int   guard = 0;
        logic rdy;
        req_valid_in = 1'b1;
        drive_item(first);
        while (sent < n && guard < 60) begin
            rdy = req_ready_out;
            @(negedge clk_in);
            guard++;
            if (rdy) begin
                sent++;
                if (sent < n) drive_item(first + sent);
            end
        end
        req_valid_in = 1'b0;
        check_output("stream_accepted", sent, n);
    endtask

    task automatic wait_rsp(input int max_cycles);
        int guard = 0;
        while (!rsp_valid_out && guard < max_cycles) begin
            @(negedge clk_in);
            guard++;
        end
        check_output("rsp_timeout", {31'b0, rsp_valid_out}, 32'd1);
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] cmd,
                          input logic [15:0] exp_d, input string name);
        apply_stimulus(a, b, cmd);
        wait_rsp(20);
        check_output({name, "_data"}, {16'b0, rsp_data_out}, {16'b0, exp_d});
        check_output({name, "_err"}, {31'b0, rsp_err_out}, 32'd0);
        @(negedge clk_in);
    endtask

    task automatic drain(input int max_cycles);
        int guard = 0;
        rsp_ready_in = 1'b1;
        while ((exp_q.size() != 0 || rsp_valid_out) && guard < max_cycles) begin
            @(negedge clk_in);
            guard++;
        end
        check_output("drain_empty", exp_q.size(), 0);
    endtask

    logic [15:0] bp_exp [5];
    int          rsp_times [5];
    int          got;
    int          seen;
    logic        oe_seen;

    initial begin
        set_item(0, 8'h01, 8'h02, 4'h0);
        set_item(1, 8'h01, 8'h10, 4'h1);
        set_item(2, 8'h50, 8'h05, 4'h3);
        set_item(3, 8'h00, 8'h00, 4'h4);
        set_item(4, 8'hFF, 8'hFF, 4'h0);
        set_item(5, 8'h12, 8'h34, 4'h2);
        for (int i = 6; i < 20; i++) set_item(i, 8'h00, 8'h00, 4'h0);
        set_item(8,  8'h10, 8'h20, 4'h0);
        set_item(9,  8'h20, 8'h10, 4'h1);
        set_item(10, 8'hF0, 8'h3C, 4'h2);
        set_item(11, 8'hF0, 8'h0F, 4'h3);
        set_item(12, 8'h0F, 8'h00, 4'h4);
        set_item(13, 8'h80, 8'h80, 4'h0);
        set_item(14, 8'h00, 8'h01, 4'h1);
        set_item(15, 8'h01, 8'h01, 4'h0);
        set_item(16, 8'h02, 8'h02, 4'h0);
        set_item(17, 8'h03, 8'h03, 4'h0);
        bp_exp[0] = 16'h0003;
        bp_exp[1] = 16'h000F;
        bp_exp[2] = 16'h0055;
        bp_exp[3] = 16'hFFFF;
        bp_exp[4] = 16'h01FE;

        rst_in       = 1'b1;
        req_valid_in = 1'b0;
        req_a_in     = '0;
        req_b_in     = '0;
        req_cmd_in   = '0;
        rsp_ready_in = 1'b0;
        repeat (3) @(negedge clk_in);
        check_output("rst_ready", {31'b0, req_ready_out}, 32'd1);
        check_output("rst_alu_a", {24'b0, alu_a_out}, 32'h0);
        check_output("rst_alu_b", {24'b0, alu_b_out}, 32'h0);
        check_output("rst_alu_cmd", {28'b0, alu_cmd_out}, 32'hF);
        check_output("rst_alu_oe", {31'b0, alu_oe_out}, 32'd0);
        check_output("rst_rsp_valid", {31'b0, rsp_valid_out}, 32'd0);
        check_output("rst_rsp_data", {16'b0, rsp_data_out}, 32'h0);
        check_output("rst_rsp_err", {31'b0, rsp_err_out}, 32'd0);
        rst_in = 1'b0;
        @(negedge clk_in);

        $display("[TB] ADD latency");
        rsp_ready_in = 1'b1;
        req_valid_in = 1'b1;
        req_a_in     = 8'h05;
        req_b_in     = 8'h03;
        req_cmd_in   = 4'h0;
        @(negedge clk_in);
        req_valid_in = 1'b0;
        check_output("lat_n0_valid", {31'b0, rsp_valid_out}, 32'd0);
        @(negedge clk_in);
        check_output("lat_issue_a", {24'b0, alu_a_out}, 32'h05);
        check_output("lat_issue_b", {24'b0, alu_b_out}, 32'h03);
        check_output("lat_issue_cmd", {28'b0, alu_cmd_out}, 32'h0);
        check_output("lat_issue_oe", {31'b0, alu_oe_out}, 32'd0);
        @(negedge clk_in);
        check_output("lat_capture_oe", {31'b0, alu_oe_out}, 32'd1);
        check_output("lat_capture_valid", {31'b0, rsp_valid_out}, 32'd0);
        @(negedge clk_in);
        check_output("lat_resp_valid", {31'b0, rsp_valid_out}, 32'd1);
        check_output("lat_resp_data", {16'b0, rsp_data_out}, 32'h0008);
        check_output("lat_resp_oe", {31'b0, alu_oe_out}, 32'd0);
        check_output("lat_resp_cmd", {28'b0, alu_cmd_out}, 32'hF);
        @(negedge clk_in);
        check_output("lat_done_valid", {31'b0, rsp_valid_out}, 32'd0);

        $display("[TB] directed ops");
        run_op(8'h05, 8'h03, 4'h1, 16'hFFFE, "sub_wrap");
        run_op(8'h03, 8'h05, 4'h1, 16'h0002, "sub_pos");
        run_op(8'hA5, 8'h00, 4'h4, 16'hFF5A, "not_a");
        run_op(8'hF0, 8'h3C, 4'h2, 16'h0030, "and");
        run_op(8'hF0, 8'h3C, 4'h3, 16'h00FC, "or");

        $display("[TB] illegal command");
        apply_stimulus(8'h12, 8'h34, 4'h7);
        oe_seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (alu_oe_out) oe_seen = 1'b1;
            if (rsp_valid_out) break;
            @(negedge clk_in);
        end
        check_output("illegal_valid", {31'b0, rsp_valid_out}, 32'd1);
        check_output("illegal_data", {16'b0, rsp_data_out}, 32'h0000);
`ifdef ALU_SEQ_CMD_CHECK_EN
        check_output("illegal_err", {31'b0, rsp_err_out}, 32'd1);
        check_output("illegal_oe_seen", {31'b0, oe_seen}, 32'd0);
`else
        check_output("illegal_err", {31'b0, rsp_err_out}, 32'd0);
        check_output("illegal_oe_seen", {31'b0, oe_seen}, 32'd1);
`endif
        @(negedge clk_in);

        $display("[TB] back-pressure");
        rsp_ready_in = 1'b0;
        stream_items(0, 5);
        check_output("bp_ready_low", {31'b0, req_ready_out}, 32'd0);
        req_valid_in = 1'b1;
        drive_item(5);
        repeat (3) @(negedge clk_in);
        check_output("bp_ready_still_low", {31'b0, req_ready_out}, 32'd0);
        req_valid_in = 1'b0;
        rsp_ready_in = 1'b1;
        got = 0;
        for (int c = 0; c < 40 && got < 5; c++) begin
            if (rsp_valid_out) begin
                check_output("bp_order_data", {16'b0, rsp_data_out}, {16'b0, bp_exp[got]});
                rsp_times[got] = c;
                got++;
            end
            @(negedge clk_in);
        end
        check_output("bp_rsp_count", got, 5);
        for (int i = 1; i < 5; i++) check_output("bp_spacing", rsp_times[i] - rsp_times[i-1], 3);
        drain(20);

        $display("[TB] push and pop at DEPTH-1");
        rsp_ready_in = 1'b0;
        stream_items(8, 4);
        check_output("pp_resp_valid", {31'b0, rsp_valid_out}, 32'd1);
        check_output("pp_ready_cnt3", {31'b0, req_ready_out}, 32'd1);
        req_valid_in = 1'b1;
        drive_item(12);
        rsp_ready_in = 1'b1;
        @(negedge clk_in);
        req_valid_in = 1'b0;
        rsp_ready_in = 1'b0;
        check_output("pp_ready_after", {31'b0, req_ready_out}, 32'd1);
        req_valid_in = 1'b1;
        drive_item(13);
        @(negedge clk_in);
        req_valid_in = 1'b0;
        check_output("pp_full_ready", {31'b0, req_ready_out}, 32'd0);
        wait_rsp(10);
        req_valid_in = 1'b1;
        drive_item(14);
        rsp_ready_in = 1'b1;
        @(negedge clk_in);
        req_valid_in = 1'b0;
        check_output("full_push_refused", {31'b0, req_ready_out}, 32'd1);
        drain(60);

        $display("[TB] reset during capture");
        rsp_ready_in = 1'b1;
        stream_items(15, 3);
        check_output("mid_capture_oe", {31'b0, alu_oe_out}, 32'd1);
        rst_in = 1'b1;
        @(negedge clk_in);
        check_output("mid_rst_ready", {31'b0, req_ready_out}, 32'd1);
        check_output("mid_rst_cmd", {28'b0, alu_cmd_out}, 32'hF);
        check_output("mid_rst_oe", {31'b0, alu_oe_out}, 32'd0);
        check_output("mid_rst_valid", {31'b0, rsp_valid_out}, 32'd0);
        check_output("mid_rst_data", {16'b0, rsp_data_out}, 32'h0);
        rst_in = 1'b0;
        seen = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk_in);
            if (rsp_valid_out) seen++;
        end
        check_output("mid_rst_no_rsp", seen, 0);
        check_output("final_q_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
